// File: rtl/gbf_multibank_rd_ctrl.sv
// GBF multi-bank read controller: streams bank words round-robin into requesting RF buffers (optional GBF_STALL_CNT_EN adds stall_cnt).
// Latency: rf_we/rf_w_addr/rd_bank_sel follow gbf_en by 1 cycle; rf_send_finish pulses 1 cycle after the last rf_we.
// Backpressure: reads stall in WAIT_BANK while the current bank is EMPTY; RFs are served only while rf_need_data is high.
module gbf_multibank_rd_ctrl #(
  parameter int NUM_BANK          = 2,
  parameter int NUM_RF            = 2,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int GBF_DEPTH         = 32,
  parameter int RF_ADDR_BITWIDTH  = 2,
  parameter int RF_DEPTH          = 4,
  parameter int REUSE_BITWIDTH    = 4,
  localparam int BANK_SEL_W       = $clog2(NUM_BANK)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      finish,
  input  logic [REUSE_BITWIDTH-1:0]                 cfg_reuse,
  input  logic [NUM_BANK-1:0]                       bank_ready,
  input  logic [NUM_BANK*(GBF_ADDR_BITWIDTH+1)-1:0] bank_len,
  input  logic [NUM_RF-1:0]                         rf_need_data,
  output logic [NUM_BANK-1:0]                       bank_need_data,
  output logic [NUM_BANK-1:0]                       gbf_en,
  output logic [GBF_ADDR_BITWIDTH-1:0]              gbf_addr,
  output logic [BANK_SEL_W-1:0]                     rd_bank_sel,
  output logic [NUM_RF-1:0]                         rf_we,
  output logic [RF_ADDR_BITWIDTH-1:0]               rf_w_addr,
  output logic [NUM_RF-1:0]                         rf_send_finish,
  output logic                                      busy
`ifdef GBF_STALL_CNT_EN
  ,
  output logic [31:0]                               stall_cnt
`endif
);

  localparam int LEN_W    = GBF_ADDR_BITWIDTH + 1;
  localparam int RF_SEL_W = (NUM_RF > 1) ? $clog2(NUM_RF) : 1;

  typedef enum logic [1:0] {IDLE, ARB, READ, WAIT_BANK} state_t;

  state_t                       state;
  logic [NUM_BANK-1:0]          bank_full;
  logic [LEN_W-1:0]             bank_len_q [NUM_BANK];
  logic [BANK_SEL_W-1:0]        cur;
  logic [GBF_ADDR_BITWIDTH-1:0] rd_ptr;
  logic [REUSE_BITWIDTH-1:0]    pass_cnt;
  logic [REUSE_BITWIDTH-1:0]    reuse_q;
  logic [RF_SEL_W-1:0]          rr_ptr;
  logic [RF_SEL_W-1:0]          grant;
  logic [RF_ADDR_BITWIDTH-1:0]  word_cnt;
  logic [NUM_RF-1:0]            rf_mask;
  logic [NUM_RF-1:0]            last_q;

  logic                         rd_fire;
  logic [LEN_W-1:0]             cur_len;
  logic                         ptr_wrap;
  logic                         pass_done;
  logic                         bank_free;
  logic                         xfer_last;
  logic [BANK_SEL_W-1:0]        cur_nxt;
  logic                         arb_found;
  logic [RF_SEL_W-1:0]          arb_idx;

  assign rd_fire   = (state == READ);
  assign cur_len   = bank_len_q[cur];
  assign ptr_wrap  = rd_fire && ({1'b0, rd_ptr} == cur_len - 1'b1);
  assign pass_done = (pass_cnt == reuse_q - 1'b1);
  assign bank_free = ptr_wrap && pass_done;
  assign xfer_last = rd_fire && (word_cnt == RF_ADDR_BITWIDTH'(RF_DEPTH - 1));
  assign cur_nxt   = (cur == BANK_SEL_W'(NUM_BANK - 1)) ? '0 : cur + 1'b1;

  assign gbf_en         = rd_fire ? (NUM_BANK'(1) << cur) : '0;
  assign gbf_addr       = rd_ptr;
  assign busy           = (state != IDLE);
  assign bank_need_data = ~bank_full;

  // Round-robin search starting at rr_ptr over unmasked requesters.
  always_comb begin : arb
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_RF; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_RF) idx = idx - NUM_RF;
      if (!arb_found && rf_need_data[idx] && !rf_mask[idx]) begin
        arb_found = 1'b1;
        arb_idx   = RF_SEL_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      bank_full      <= '0;
      for (int b = 0; b < NUM_BANK; b++) bank_len_q[b] <= '0;
      cur            <= '0;
      rd_ptr         <= '0;
      pass_cnt       <= '0;
      reuse_q        <= '0;
      rr_ptr         <= '0;
      grant          <= '0;
      word_cnt       <= '0;
      rf_mask        <= '0;
      last_q         <= '0;
      rf_we          <= '0;
      rf_w_addr      <= '0;
      rd_bank_sel    <= '0;
      rf_send_finish <= '0;
    end else begin
      rf_we          <= '0;
      last_q         <= '0;
      rf_send_finish <= last_q;
      if (rd_fire) begin
        rf_we       <= NUM_RF'(1) << grant;
        rf_w_addr   <= word_cnt;
        rd_bank_sel <= cur;
        if (xfer_last) last_q <= NUM_RF'(1) << grant;
      end

      // A bank being freed is still FULL this cycle, so its bank_ready is dropped.
      for (int b = 0; b < NUM_BANK; b++) begin
        if (bank_ready[b] && !bank_full[b] &&
            bank_len[b*LEN_W +: LEN_W] != '0 &&
            bank_len[b*LEN_W +: LEN_W] <= LEN_W'(GBF_DEPTH)) begin
          bank_full[b]  <= 1'b1;
          bank_len_q[b] <= bank_len[b*LEN_W +: LEN_W];
        end
      end
      if (bank_free) bank_full[cur] <= 1'b0;

      // Mask from the end of a transfer so the same RF is not regranted before it drops its request.
      for (int r = 0; r < NUM_RF; r++) begin
        if (xfer_last && grant == RF_SEL_W'(r)) rf_mask[r] <= 1'b1;
        else if (!rf_need_data[r])             rf_mask[r] <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= ARB;
            reuse_q <= (cfg_reuse == '0) ? REUSE_BITWIDTH'(1) : cfg_reuse;
          end
        end
        ARB: begin
          if (arb_found) begin
            grant    <= arb_idx;
            word_cnt <= '0;
            state    <= bank_full[cur] ? READ : WAIT_BANK;
          end
        end
        READ: begin
          if (ptr_wrap) begin
            rd_ptr <= '0;
            if (pass_done) begin
              pass_cnt <= '0;
              cur      <= cur_nxt;
            end else begin
              pass_cnt <= pass_cnt + 1'b1;
            end
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
          if (xfer_last) begin
            state  <= ARB;
            rr_ptr <= (grant == RF_SEL_W'(NUM_RF - 1)) ? '0 : grant + 1'b1;
          end else begin
            word_cnt <= word_cnt + 1'b1;
            if (bank_free && !bank_full[cur_nxt]) state <= WAIT_BANK;
          end
        end
        WAIT_BANK: begin
          if (bank_full[cur]) state <= READ;
        end
        default: state <= IDLE;
      endcase

      if (finish) begin
        state          <= IDLE;
        bank_full      <= '0;
        rf_mask        <= '0;
        rf_we          <= '0;
        last_q         <= '0;
        rf_send_finish <= '0;
        cur            <= '0;
        rd_ptr         <= '0;
        pass_cnt       <= '0;
        word_cnt       <= '0;
        rr_ptr         <= '0;
      end
    end
  end

`ifdef GBF_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if ((state == WAIT_BANK || (state == ARB && |rf_need_data && !bank_full[cur]))
                 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gbf_multibank_rd_ctrl.sv
// Directed self-checking bench for gbf_multibank_rd_ctrl (2-bank/2-RF instance plus a 3-bank/1-RF instance).
module tb_gbf_multibank_rd_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, finish = 1'b0;
  logic [3:0]  cfg_reuse = '0;
  logic [1:0]  bank_ready = '0;
  logic [11:0] bank_len = '0;
  logic [1:0]  rf_need_data = '0;
  logic [1:0]  bank_need_data, gbf_en, rf_we, rf_send_finish, rf_w_addr;
  logic [4:0]  gbf_addr;
  logic [0:0]  rd_bank_sel;
  logic        busy;

  logic        d3_start = 1'b0, d3_finish = 1'b0;
  logic [3:0]  d3_cfg_reuse = '0;
  logic [2:0]  d3_bank_ready = '0;
  logic [17:0] d3_bank_len = '0;
  logic [0:0]  d3_rf_need = '0;
  logic [2:0]  d3_need, d3_gbf_en;
  logic [4:0]  d3_addr;
  logic [1:0]  d3_sel, d3_waddr;
  logic [0:0]  d3_we, d3_sf;
  logic        d3_busy;
`ifdef GBF_STALL_CNT_EN
  logic [31:0] stall_cnt, d3_stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int rd_log[$];
  int we_log[$];
  int sf_log[$];
  int rd3_log[$];

  gbf_multibank_rd_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .cfg_reuse(cfg_reuse),
    .bank_ready(bank_ready), .bank_len(bank_len), .rf_need_data(rf_need_data),
    .bank_need_data(bank_need_data), .gbf_en(gbf_en), .gbf_addr(gbf_addr),
    .rd_bank_sel(rd_bank_sel), .rf_we(rf_we), .rf_w_addr(rf_w_addr),
    .rf_send_finish(rf_send_finish), .busy(busy)
`ifdef GBF_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  gbf_multibank_rd_ctrl #(.NUM_BANK(3), .NUM_RF(1)) u_dut3 (
    .clk(clk), .reset(reset), .start(d3_start), .finish(d3_finish), .cfg_reuse(d3_cfg_reuse),
    .bank_ready(d3_bank_ready), .bank_len(d3_bank_len), .rf_need_data(d3_rf_need),
    .bank_need_data(d3_need), .gbf_en(d3_gbf_en), .gbf_addr(d3_addr),
    .rd_bank_sel(d3_sel), .rf_we(d3_we), .rf_w_addr(d3_waddr),
    .rf_send_finish(d3_sf), .busy(d3_busy)
`ifdef GBF_STALL_CNT_EN
    , .stall_cnt(d3_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int oh2i(input logic [7:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < 8; i++) if (v[i]) begin idx = i; cnt++; end
    return (cnt == 1) ? idx : -1;
  endfunction

  // Advance one clock and sample 1ns after the edge; logs reads, writes and finish pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (gbf_en != 0) rd_log.push_back(oh2i(8'(gbf_en)) * 100 + int'(gbf_addr));
    if (rf_we != 0) we_log.push_back(oh2i(8'(rf_we)) * 1000 + int'(rd_bank_sel) * 100 + int'(rf_w_addr));
    if (rf_send_finish != 0) sf_log.push_back(oh2i(8'(rf_send_finish)));
    if (d3_gbf_en != 0) rd3_log.push_back(oh2i(8'(d3_gbf_en)) * 100 + int'(d3_addr));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_chk++; if (gbf_en !== 2'b00) begin n_fail++; $display("FAIL reset_gbf_en: got %b want 00", gbf_en); end
    n_chk++; if (rf_we !== 2'b00) begin n_fail++; $display("FAIL reset_rf_we: got %b want 00", rf_we); end
    n_chk++; if (rf_send_finish !== 2'b00) begin n_fail++; $display("FAIL reset_sf: got %b want 00", rf_send_finish); end
    n_chk++; if (bank_need_data !== 2'b11) begin n_fail++; $display("FAIL reset_need: got %b want 11", bank_need_data); end
    n_chk++; if (gbf_addr !== 5'd0 || rf_w_addr !== 2'd0 || rd_bank_sel !== 1'b0) begin
      n_fail++; $display("FAIL reset_addr: got %0d/%0d/%0d want 0/0/0", gbf_addr, rf_w_addr, rd_bank_sel); end
    n_chk++; if (d3_need !== 3'b111 || d3_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_d3: need %b busy %b want 111/0", d3_need, d3_busy); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    int exp_en   [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
    int exp_addr [11] = '{0, 1, 2, 3, 0, 4, 5, 6, 7, 0, 0};
    int exp_we   [11] = '{0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 0};
    int exp_wa   [11] = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3, 0};
    int exp_sf   [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
    int exp_need [11] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 3};
    bit found = 0;
    cfg_reuse = 4'd1; start = 1'b1; bank_ready = 2'b01; bank_len[5:0] = 6'd8; rf_need_data = 2'b11;
    tick();
    start = 1'b0; bank_ready = 2'b00;
    n_chk++; if (busy !== 1'b1 || bank_need_data !== 2'b10) begin
      n_fail++; $display("FAIL stream_start: busy %b need %b want 1/10", busy, bank_need_data); end
    for (int i = 0; i < 10; i++) begin
      if (gbf_en != 0) begin found = 1; break; end
      tick();
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL stream_first_read: no gbf_en within 10 cycles"); end
    for (int k = 0; k < 11; k++) begin
      n_chk++; if (gbf_en !== 2'(exp_en[k])) begin
        n_fail++; $display("FAIL stream_gbf_en[%0d]: got %b want %0d", k, gbf_en, exp_en[k]); end
      if (exp_en[k] != 0) begin
        n_chk++; if (gbf_addr !== 5'(exp_addr[k])) begin
          n_fail++; $display("FAIL stream_gbf_addr[%0d]: got %0d want %0d", k, gbf_addr, exp_addr[k]); end
      end
      n_chk++; if (rf_we !== 2'(exp_we[k])) begin
        n_fail++; $display("FAIL stream_rf_we[%0d]: got %b want %0d", k, rf_we, exp_we[k]); end
      if (exp_we[k] != 0) begin
        n_chk++; if (rf_w_addr !== 2'(exp_wa[k]) || rd_bank_sel !== 1'b0) begin
          n_fail++; $display("FAIL stream_w_addr[%0d]: got %0d sel %0d want %0d sel 0", k, rf_w_addr, rd_bank_sel, exp_wa[k]); end
      end
      n_chk++; if (rf_send_finish !== 2'(exp_sf[k])) begin
        n_fail++; $display("FAIL stream_sf[%0d]: got %b want %0d", k, rf_send_finish, exp_sf[k]); end
      n_chk++; if (bank_need_data !== 2'(exp_need[k])) begin
        n_fail++; $display("FAIL stream_need[%0d]: got %b want %0d", k, bank_need_data, exp_need[k]); end
      tick();
    end
    finish = 1'b1; rf_need_data = 2'b00;
    tick();
    finish = 1'b0;
    tick();
  endtask

  task automatic test_reuse();
    int nrd = 0;
    int extra;
    cfg_reuse = 4'd3; start = 1'b1; bank_ready = 2'b01; bank_len[5:0] = 6'd4; rf_need_data = 2'b01;
    tick();
    start = 1'b0; bank_ready = 2'b00;
    for (int cyc = 0; cyc < 150 && nrd < 12; cyc++) begin
      tick();
      if (rf_need_data[0] == 1'b0) rf_need_data[0] = 1'b1;
      if (gbf_en != 0) begin
        n_chk++; if (gbf_en !== 2'b01 || gbf_addr !== 5'(nrd % 4) || bank_need_data[0] !== 1'b0) begin
          n_fail++; $display("FAIL reuse_read[%0d]: en %b addr %0d need0 %b want 01/%0d/0", nrd, gbf_en, gbf_addr, bank_need_data[0], nrd % 4); end
        nrd++;
      end
      if (rf_send_finish[0]) rf_need_data[0] = 1'b0;
    end
    n_chk++; if (nrd != 12) begin n_fail++; $display("FAIL reuse_count: got %0d reads want 12", nrd); end
    tick();
    n_chk++; if (bank_need_data[0] !== 1'b1) begin n_fail++; $display("FAIL reuse_free: need0 %b want 1", bank_need_data[0]); end
    extra = rd_log.size();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rf_need_data[0] == 1'b0) rf_need_data[0] = 1'b1;
      if (rf_send_finish[0]) rf_need_data[0] = 1'b0;
    end
    n_chk++; if (rd_log.size() != extra) begin
      n_fail++; $display("FAIL reuse_no_extra: got %0d extra reads want 0", rd_log.size() - extra); end
    finish = 1'b1; rf_need_data = 2'b00;
    tick();
    finish = 1'b0;
  endtask

  task automatic test_span();
    int exp_rd [8] = '{0, 1, 2, 3, 4, 5, 100, 101};
    int exp_we [8] = '{0, 1, 2, 3, 1000, 1001, 1102, 1103};
    rd_log.delete(); we_log.delete(); sf_log.delete();
    cfg_reuse = 4'd1; start = 1'b1; bank_ready = 2'b01; bank_len[5:0] = 6'd6; rf_need_data = 2'b11;
    tick();
    start = 1'b0; bank_ready = 2'b00;
    for (int i = 0; i < 40 && rd_log.size() < 6; i++) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (gbf_en !== 2'b00 || busy !== 1'b1) begin
        n_fail++; $display("FAIL span_wait[%0d]: en %b busy %b want 00/1", i, gbf_en, busy); end
    end
    bank_ready = 2'b10; bank_len[11:6] = 6'd4;
    tick();
    bank_ready = 2'b00;
    for (int i = 0; i < 20 && rd_log.size() < 8; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    n_chk++; if (rd_log.size() != 8 || we_log.size() != 8 || sf_log.size() != 2) begin
      n_fail++; $display("FAIL span_sizes: rd %0d we %0d sf %0d want 8/8/2", rd_log.size(), we_log.size(), sf_log.size()); end
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (i >= rd_log.size() || rd_log[i] != exp_rd[i]) begin
        n_fail++; $display("FAIL span_rd[%0d]: got %0d want %0d", i, (i < rd_log.size()) ? rd_log[i] : -1, exp_rd[i]); end
      n_chk++; if (i >= we_log.size() || we_log[i] != exp_we[i]) begin
        n_fail++; $display("FAIL span_we[%0d]: got %0d want %0d", i, (i < we_log.size()) ? we_log[i] : -1, exp_we[i]); end
    end
    n_chk++; if (sf_log.size() < 2 || sf_log[0] != 0 || sf_log[1] != 1) begin
      n_fail++; $display("FAIL span_sf_order: got %0d entries want RF0 then RF1", sf_log.size()); end
    finish = 1'b1; rf_need_data = 2'b00;
    tick();
    finish = 1'b0;
  endtask

  task automatic test_finish();
    bit found = 0;
    cfg_reuse = 4'd1; start = 1'b1; bank_ready = 2'b01; bank_len[5:0] = 6'd8; rf_need_data = 2'b01;
    tick();
    start = 1'b0; bank_ready = 2'b00;
    for (int i = 0; i < 10; i++) begin
      if (gbf_en != 0) begin found = 1; break; end
      tick();
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL finish_first_read: no gbf_en within 10 cycles"); end
    tick(); tick(); tick();
    n_chk++; if (gbf_addr !== 5'd3 || rf_we !== 2'b01 || rf_w_addr !== 2'd2) begin
      n_fail++; $display("FAIL finish_inflight: addr %0d we %b waddr %0d want 3/01/2", gbf_addr, rf_we, rf_w_addr); end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    n_chk++; if (busy !== 1'b0 || gbf_en !== 2'b00 || rf_we !== 2'b00) begin
      n_fail++; $display("FAIL finish_stop: busy %b en %b we %b want 0/00/00", busy, gbf_en, rf_we); end
    n_chk++; if (bank_need_data !== 2'b11) begin n_fail++; $display("FAIL finish_need: got %b want 11", bank_need_data); end
    tick();
    n_chk++; if (rf_send_finish !== 2'b00) begin n_fail++; $display("FAIL finish_no_sf: got %b want 00", rf_send_finish); end
    rf_need_data = 2'b00; bank_ready = 2'b10; bank_len[11:6] = 6'd3;
    tick();
    bank_ready = 2'b00;
    n_chk++; if (bank_need_data !== 2'b01) begin n_fail++; $display("FAIL finish_refill: got %b want 01", bank_need_data); end
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic test_multibank();
    int exp_rd [16] = '{0, 1, 2, 3, 100, 101, 102, 103, 200, 201, 202, 203, 0, 1, 2, 3};
    bit refilled = 0;
    rd3_log.delete();
    d3_cfg_reuse = 4'd1; d3_start = 1'b1; d3_bank_ready = 3'b111;
    d3_bank_len = {6'd4, 6'd4, 6'd4}; d3_rf_need = 1'b1;
    tick();
    d3_start = 1'b0; d3_bank_ready = 3'b000;
    for (int cyc = 0; cyc < 200 && rd3_log.size() < 16; cyc++) begin
      tick();
      d3_bank_ready = 3'b000;
      if (cyc == 2) begin
        n_chk++; if (d3_need[1] !== 1'b0) begin n_fail++; $display("FAIL mb_bank1_full: need1 %b want 0", d3_need[1]); end
        d3_bank_ready[1] = 1'b1; d3_bank_len[11:6] = 6'd2;
      end
      if (d3_need[0] && !refilled) begin
        d3_bank_ready[0] = 1'b1; d3_bank_len[5:0] = 6'd4; refilled = 1;
      end
      if (d3_rf_need[0] == 1'b0) d3_rf_need[0] = 1'b1;
      if (d3_sf[0]) d3_rf_need[0] = 1'b0;
    end
    d3_bank_ready = 3'b000;
    n_chk++; if (rd3_log.size() != 16) begin n_fail++; $display("FAIL mb_count: got %0d reads want 16", rd3_log.size()); end
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (i >= rd3_log.size() || rd3_log[i] != exp_rd[i]) begin
        n_fail++; $display("FAIL mb_rd[%0d]: got %0d want %0d", i, (i < rd3_log.size()) ? rd3_log[i] : -1, exp_rd[i]); end
    end
    tick();
    n_chk++; if (d3_need !== 3'b111) begin n_fail++; $display("FAIL mb_all_free: got %b want 111", d3_need); end
    d3_finish = 1'b1; d3_rf_need = 1'b0;
    tick();
    d3_finish = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found = 0;
    cfg_reuse = 4'd1; start = 1'b1; bank_ready = 2'b01; bank_len[5:0] = 6'd8; rf_need_data = 2'b01;
    tick();
    start = 1'b0; bank_ready = 2'b00;
    for (int i = 0; i < 10; i++) begin
      if (gbf_en != 0) begin found = 1; break; end
      tick();
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL arst_first_read: no gbf_en within 10 cycles"); end
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || gbf_en !== 2'b00 || rf_we !== 2'b00 || rf_send_finish !== 2'b00) begin
      n_fail++; $display("FAIL arst_ctrl: busy %b en %b we %b sf %b want 0/00/00/00", busy, gbf_en, rf_we, rf_send_finish); end
    n_chk++; if (bank_need_data !== 2'b11 || gbf_addr !== 5'd0 || rf_w_addr !== 2'd0) begin
      n_fail++; $display("FAIL arst_data: need %b addr %0d waddr %0d want 11/0/0", bank_need_data, gbf_addr, rf_w_addr); end
    rf_need_data = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    n_chk++; if (busy !== 1'b0 || rf_send_finish !== 2'b00) begin
      n_fail++; $display("FAIL arst_release: busy %b sf %b want 0/00", busy, rf_send_finish); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reuse();
    test_span();
    test_finish();
    test_multibank();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
